ps2_key_ctrl: RTL and testbench
===============================

# ps2_key_ctrl

Key-event controller downstream of the PS/2 byte receiver. Consumes validated scan-code bytes (Set 2), resolves the E0 (extended), F0 (break) and E1 (Pause) prefix sequences with a state machine, and queues one event per completed key action in a small FIFO. The FIFO is drained by the consumer (CPU/display logic) over a valid/ready handshake. Also handles receiver error recovery, prefix timeout and overflow reporting.

## Interface
- Clocking: one clock; reset is synchronous and active-high. Ports `clk` and `rst`.
- `FIFO_DEPTH`, 8: event FIFO entries; power of two, at least 2.
- `TIMEOUT_CYCLES`, 1000000: idle cycles allowed between bytes of one prefix sequence (20 ms at 50 MHz).
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `rx_valid`  in  1  one-cycle strobe: a received byte is present.
- `rx_data`  in  8  received byte; qualified by `rx_valid`.
- `rx_err`  in  1  parity/framing error on this byte; qualified by `rx_valid`.
- `ev_valid`  out  1  FIFO non-empty.
- `ev_ready`  in  1  consumer accepts the head event.
- `ev_code`  out  8  head event scan code.
- `ev_ext`  out  1  head event extended (E0) flag.
- `ev_break`  out  1  head event break (release) flag.
- `overflow`  out  1  sticky: an event was dropped because the FIFO was full.
- `clear_overflow`  in  1  clears `overflow`.
- `rx_errors`  out  8  saturating count of `rx_err` bytes.
- `busy`  out  1  high when the FSM is not in IDLE (prefix pending).

## Operation
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), PAUSE (E1 seen).
- Transitions happen only on `rx_valid`, except for timeout.
- IDLE:
  - E0 → EXT.
  - F0 → BRK.
  - E1 → PAUSE, with `skip_cnt` set to 7.
  - FA, AA, EE, FE, 00, FF → dropped, stay in IDLE.
  - Any other byte → push {code, ext=0, brk=0}.
- EXT: F0 → EXT_BRK. Any other byte → push {code, ext=1, brk=0}, then IDLE.
- BRK: any byte → push {code, 0, 1}, then IDLE.
- EXT_BRK: any byte → push {code, 1, 1}, then IDLE.
- PAUSE: each byte decrements `skip_cnt`. On the byte that takes it 1→0, push {E1, 1, 0} and go to IDLE. Byte contents in PAUSE are ignored.
- `rx_err` with `rx_valid`, in any state:
  - Go to IDLE and clear `skip_cnt`.
  - No push.
  - `rx_errors` increments, saturating at 255.
- Timeout: `tmo_cnt` resets on every `rx_valid` and counts while `busy`. When it reaches `TIMEOUT_CYCLES - 1`, go to IDLE with no push. `tmo_cnt` is held at 0 in IDLE.
- FIFO push while full:
  - If a pop happens in the same cycle, the push is accepted and the count is unchanged.
  - Otherwise the event is dropped and `overflow` is set.
- `overflow` set and `clear_overflow` in the same cycle: set wins.
- Pop occurs when `ev_valid && ev_ready`. `ev_ready` while empty has no effect.
- Head outputs come from the FIFO read pointer (show-ahead). They are stable while `ev_valid` is high and not popped.

## Timing
- Reset: state IDLE, FIFO empty, all counters 0. Outputs after reset: `ev_valid`=0, `ev_code`=0, `ev_ext`=0, `ev_break`=0, `overflow`=0, `rx_errors`=0, `busy`=0. FIFO storage does not need resetting, but head outputs are forced to 0 while empty.
- Latency: a completing byte with `rx_valid` in cycle N gives `ev_valid`=1 in cycle N+1, when the FIFO was empty.
- Prefix bytes produce no output change except `busy`, which goes high in cycle N+1.
- Pop in cycle N: the next entry is presented in N+1, or `ev_valid` drops to 0.
- Back-to-back `rx_valid` on consecutive cycles is supported.
- `rst` mid-sequence aborts the sequence and discards FIFO contents.

## Structure
- Shared package `ps2_pkg` holds:
  - the FSM state encoding;
  - byte constants PFX_EXT=E0, PFX_BRK=F0, PFX_PAUSE=E1 and PAUSE_LEN=7;
  - the drop-set codes;
  - the event width (10 bits: {ext, brk, code}).
- Sub-module `ps2_event_fifo`: synchronous FIFO, parameterised depth and width, show-ahead read, `full`/`empty`, push-while-full-with-pop rule as above.
- Top level contains the FSM, `skip_cnt`, `tmo_cnt`, the error counter and the overflow flag.

## Test plan
- Bytes 1C; F0 1C → events {1C,0,0} then {1C,0,1}; `ev_valid` rises the cycle after the 1C strobe.
- Bytes E0 75; E0 F0 75 → events {75,1,0} then {75,1,1}; `busy`=1 between prefix and code.
- E1 14 77 E1 F0 14 F0 77 → exactly one event {E1,1,0}; no events for the intermediate bytes.
- E0, then no byte for `TIMEOUT_CYCLES`, then 1C → `busy` drops; event is {1C,0,0}, not extended.
- F0 with `rx_err`=1, then 1C → no break event; event {1C,0,0}; `rx_errors`=1. Send 300 error bytes → `rx_errors`=255.
- `ev_ready`=0, push 9 make codes with depth 8 → first 8 retained in order, `overflow`=1. Push and pop together when full → count stays 8. `clear_overflow` → `overflow`=0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key-event path: FSM encoding,
// Set 2 prefix bytes, non-key codes that never become events, event layout.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } state_e;

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;
    localparam logic [7:0] PFX_PAUSE = 8'hE1;

    localparam int              SKIP_W    = 3;
    localparam logic [SKIP_W-1:0] PAUSE_LEN = 3'd7;

    // Keyboard status/handshake replies that carry no key information.
    localparam logic [7:0] DROP_ACK    = 8'hFA;
    localparam logic [7:0] DROP_BAT    = 8'hAA;
    localparam logic [7:0] DROP_ECHO   = 8'hEE;
    localparam logic [7:0] DROP_RESEND = 8'hFE;
    localparam logic [7:0] DROP_ERR_LO = 8'h00;
    localparam logic [7:0] DROP_ERR_HI = 8'hFF;

    localparam int EV_W = 10;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ev_t;

    function automatic logic is_drop_code(input logic [7:0] b);
        return (b == DROP_ACK)    || (b == DROP_BAT)    || (b == DROP_ECHO) ||
               (b == DROP_RESEND) || (b == DROP_ERR_LO) || (b == DROP_ERR_HI);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead synchronous FIFO; head visible the cycle after the first push.
// Push while full is accepted only alongside a pop, otherwise it is refused.
module ps2_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             pop_ok, push_ok;

    assign full     = (cnt_q == (AW+1)'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign pop_ok   = pop_rdy && !empty;
    assign push_ok  = push_vld && (!full || pop_ok);
    assign head_dat = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// Turns Set 2 scan bytes into {ext, brk, code} key events queued in a FIFO.
// One-cycle byte-to-event latency; events are dropped (sticky overflow) when the FIFO is full.
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_err,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       overflow,
    input  logic       clear_overflow,
    output logic [7:0] rx_errors,
    output logic       busy
);

    localparam int                TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              overflow_q, overflow_d;
    logic              byte_vld, err_vld, tmo_hit, pause_done;
    logic              push_vld, pop_vld, fifo_full, fifo_empty;
    ev_t               push_dat, head_dat;

    assign byte_vld   = rx_valid && !rx_err;
    assign err_vld    = rx_valid && rx_err;
    // A byte arriving on the expiry cycle still belongs to the pending sequence.
    assign tmo_hit    = (state_q != ST_IDLE) && !rx_valid && (tmo_q == TMO_LAST);
    assign pause_done = (skip_q <= SKIP_W'(1));
    assign pop_vld    = !fifo_empty && ev_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (err_vld || tmo_hit) begin
            state_d = ST_IDLE;
        end else if (byte_vld) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == PFX_EXT)        state_d = ST_EXT;
                    else if (rx_data == PFX_BRK)   state_d = ST_BRK;
                    else if (rx_data == PFX_PAUSE) state_d = ST_PAUSE;
                end
                ST_EXT:   state_d = (rx_data == PFX_BRK) ? ST_EXT_BRK : ST_IDLE;
                ST_PAUSE: state_d = pause_done ? ST_IDLE : ST_PAUSE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        push_vld = 1'b0;
        push_dat = '0;
        if (byte_vld) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data != PFX_EXT && rx_data != PFX_BRK &&
                        rx_data != PFX_PAUSE && !is_drop_code(rx_data)) begin
                        push_vld = 1'b1;
                        push_dat = {1'b0, 1'b0, rx_data};
                    end
                end
                ST_EXT: begin
                    if (rx_data != PFX_BRK) begin
                        push_vld = 1'b1;
                        push_dat = {1'b1, 1'b0, rx_data};
                    end
                end
                ST_BRK: begin
                    push_vld = 1'b1;
                    push_dat = {1'b0, 1'b1, rx_data};
                end
                ST_EXT_BRK: begin
                    push_vld = 1'b1;
                    push_dat = {1'b1, 1'b1, rx_data};
                end
                ST_PAUSE: begin
                    push_vld = pause_done;
                    push_dat = {1'b1, 1'b0, PFX_PAUSE};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        skip_d = skip_q;
        if (err_vld) begin
            skip_d = '0;
        end else if (byte_vld && state_q == ST_IDLE && rx_data == PFX_PAUSE) begin
            skip_d = PAUSE_LEN;
        end else if (byte_vld && state_q == ST_PAUSE) begin
            skip_d = pause_done ? '0 : skip_q - SKIP_W'(1);
        end

        if (state_q == ST_IDLE || rx_valid || tmo_hit) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        err_cnt_d = err_cnt_q;
        if (err_vld && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end

        if (push_vld && fifo_full && !pop_vld) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skip_q     <= '0;
            tmo_q      <= '0;
            err_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            skip_q     <= skip_d;
            tmo_q      <= tmo_d;
            err_cnt_q  <= err_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_rdy  (ev_ready),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign ev_valid  = !fifo_empty;
    assign ev_code   = head_dat.code;
    assign ev_ext    = head_dat.ext;
    assign ev_break  = head_dat.brk;
    assign overflow  = overflow_q;
    assign rx_errors = err_cnt_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed and randomized byte streams checked against a prefix-queue model of
// the key-event decoder and an ideal bounded event queue.
module tb_ps2_key_ctrl;

    localparam int DEPTH = 8;
    localparam int TMO   = 40;

    logic       clk = 1'b0;
    logic       rst, rx_valid, rx_err, ev_ready, clear_overflow;
    logic [7:0] rx_data;
    logic       ev_valid, ev_ext, ev_break, overflow, busy;
    logic [7:0] ev_code, rx_errors;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: pending prefix bytes, queued events {ext, brk, code}.
    logic [7:0] pend [$];
    logic [9:0] mq   [$];
    int         m_errs;
    logic       m_ovf;
    int         idle_run;

    ps2_key_ctrl #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_err         (rx_err),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_code        (ev_code),
        .ev_ext         (ev_ext),
        .ev_break       (ev_break),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .rx_errors      (rx_errors),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_is_drop(input logic [7:0] b);
        return b == 8'hFA || b == 8'hAA || b == 8'hEE || b == 8'hFE || b == 8'h00 || b == 8'hFF;
    endfunction

    task automatic m_reset();
        pend.delete();
        mq.delete();
        m_errs   = 0;
        m_ovf    = 1'b0;
        idle_run = 0;
    endtask

    task automatic m_byte(input logic [7:0] b, input bit err, input bit pop, input bit clr);
        bit         have;
        bit         ovf_set;
        logic [9:0] ev;
        have    = 1'b0;
        ovf_set = 1'b0;
        ev      = '0;
        if (pend.size() > 0 && idle_run >= TMO) pend.delete();
        idle_run = 0;
        if (err) begin
            pend.delete();
            if (m_errs < 255) m_errs++;
        end else begin
            pend.push_back(b);
            if (pend[0] == 8'hE1) begin
                if (pend.size() == 8) begin
                    have = 1'b1;
                    ev   = {1'b1, 1'b0, 8'hE1};
                    pend.delete();
                end
            end else if ((pend.size() == 1 && (b == 8'hE0 || b == 8'hF0)) ||
                         (pend.size() == 2 && pend[0] == 8'hE0 && b == 8'hF0)) begin
                have = 1'b0;
            end else begin
                have = !(pend.size() == 1 && m_is_drop(b));
                ev   = {pend[0] == 8'hE0, pend.size() > 1 && pend[pend.size()-2] == 8'hF0, b};
                pend.delete();
            end
        end
        if (pop && mq.size() > 0) void'(mq.pop_front());
        if (have) begin
            if (mq.size() < DEPTH) mq.push_back(ev);
            else ovf_set = 1'b1;
        end
        m_ovf = ovf_set ? 1'b1 : (clr ? 1'b0 : m_ovf);
    endtask

    task automatic check_outputs(input string ctx);
        logic [9:0] h;
        h = (mq.size() > 0) ? mq[0] : 10'h0;
        chk({ctx, ":ev_valid"},  32'(ev_valid),  32'(mq.size() > 0));
        chk({ctx, ":ev_code"},   32'(ev_code),   32'(h[7:0]));
        chk({ctx, ":ev_ext"},    32'(ev_ext),    32'(h[9]));
        chk({ctx, ":ev_break"},  32'(ev_break),  32'(h[8]));
        chk({ctx, ":overflow"},  32'(overflow),  32'(m_ovf));
        chk({ctx, ":rx_errors"}, 32'(rx_errors), 32'(m_errs));
        chk({ctx, ":busy"},      32'(busy),      32'(pend.size() > 0 && idle_run < TMO));
    endtask

    // All stimulus tasks start and end just after a falling edge.
    task automatic send(input logic [7:0] b, input bit err, input bit pop, input bit clr, input string ctx);
        rx_valid       = 1'b1;
        rx_data        = b;
        rx_err         = err;
        ev_ready       = pop;
        clear_overflow = clr;
        m_byte(b, err, pop, clr);
        @(negedge clk);
        rx_valid       = 1'b0;
        rx_err         = 1'b0;
        ev_ready       = 1'b0;
        clear_overflow = 1'b0;
        check_outputs(ctx);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        idle_run += n;
    endtask

    task automatic drain(input string ctx);
        for (int k = 0; k < DEPTH + 1; k++) begin
            if (mq.size() == 0) break;
            check_outputs(ctx);
            ev_ready = 1'b1;
            @(negedge clk);
            ev_ready = 1'b0;
            idle_run++;
            void'(mq.pop_front());
        end
        check_outputs({ctx, "_empty"});
    endtask

    task automatic do_reset(input string ctx);
        rst            = 1'b1;
        rx_valid       = 1'b0;
        rx_err         = 1'b0;
        rx_data        = 8'h00;
        ev_ready       = 1'b0;
        clear_overflow = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_reset();
        check_outputs(ctx);
    endtask

    initial begin
        logic [7:0] drops [6];
        logic [7:0] b;
        int         r;
        bit         e, p;
        drops = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
        m_reset();
        do_reset("reset");

        // Plain make, then F0 break.
        send(8'h1C, 0, 0, 0, "make_1c");
        chk("make_latency", 32'(ev_valid), 32'd1);
        send(8'hF0, 0, 0, 0, "brk_pfx");
        send(8'h1C, 0, 0, 0, "brk_1c");
        drain("drain_1c");

        // Extended make and extended break.
        send(8'hE0, 0, 0, 0, "ext_pfx");
        chk("ext_busy", 32'(busy), 32'd1);
        send(8'h75, 0, 0, 0, "ext_75");
        send(8'hE0, 0, 0, 0, "extb_pfx0");
        send(8'hF0, 0, 0, 0, "extb_pfx1");
        send(8'h75, 0, 0, 0, "extb_75");
        drain("drain_75");

        // Pause sequence yields exactly one event.
        send(8'hE1, 0, 0, 0, "pause");
        foreach (drops[i]) begin
            if (i == 0) begin
                send(8'h14, 0, 0, 0, "pause_b");
                send(8'h77, 0, 0, 0, "pause_b");
                send(8'hE1, 0, 0, 0, "pause_b");
                send(8'hF0, 0, 0, 0, "pause_b");
                send(8'h14, 0, 0, 0, "pause_b");
                send(8'hF0, 0, 0, 0, "pause_b");
                send(8'h77, 0, 0, 0, "pause_end");
            end
        end
        drain("drain_pause");

        // Drop-set bytes produce nothing.
        foreach (drops[i]) send(drops[i], 0, 0, 0, "drop");
        chk("drop_none", 32'(ev_valid), 32'd0);

        // Prefix timeout: the following code is a plain make.
        send(8'hE0, 0, 0, 0, "tmo_pfx");
        idle(TMO + 5);
        check_outputs("tmo_wait");
        send(8'h1C, 0, 0, 0, "tmo_1c");
        idle(TMO / 2);
        send(8'hE0, 0, 0, 0, "tmo_short_pfx");
        idle(TMO - 5);
        send(8'h6B, 0, 0, 0, "tmo_short_6b");
        drain("drain_tmo");

        // Receiver error aborts the break prefix; counter saturates.
        send(8'hF0, 1, 0, 0, "err_f0");
        send(8'h1C, 0, 0, 0, "err_1c");
        drain("drain_err");
        for (int i = 0; i < 300; i++) send(8'($urandom), 1, 0, 0, "err_sat");
        chk("err_sat_255", 32'(rx_errors), 32'd255);

        // Overflow, push+pop when full, set-over-clear, then clear.
        for (int i = 0; i < 9; i++) send(8'(8'h15 + i), 0, 0, 0, "ovf_fill");
        chk("ovf_set", 32'(overflow), 32'd1);
        send(8'h30, 0, 1, 0, "ovf_pushpop");
        send(8'h31, 0, 0, 1, "ovf_setwins");
        clear_overflow = 1'b1;
        m_ovf          = 1'b0;
        @(negedge clk);
        clear_overflow = 1'b0;
        idle_run++;
        check_outputs("ovf_clear");
        drain("drain_ovf");

        // Reset mid-sequence discards queue and pending prefix.
        send(8'h1C, 0, 0, 0, "mid_1c");
        send(8'hE0, 0, 0, 0, "mid_pfx");
        do_reset("mid_reset");
        send(8'h75, 0, 0, 0, "mid_75");
        drain("drain_mid");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 8)       b = 8'hE0;
            else if (r < 16) b = 8'hF0;
            else if (r < 20) b = 8'hE1;
            else if (r < 26) b = drops[$urandom_range(0, 5)];
            else             b = 8'($urandom);
            e = ($urandom_range(0, 29) == 0);
            p = ($urandom_range(0, 3) == 0);
            send(b, e, p, 0, "rand");
            if ($urandom_range(0, 49) == 0) idle(TMO + 3);
            else idle($urandom_range(0, 2));
            if (mq.size() >= 6) drain("rand_drain");
        end
        drain("final_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
